// File: rtl/snd_rom_arb_pkg.sv
// ============================================================================
// snd_rom_arb_pkg : shared types and constants for the sound ROM arbiter
// Rev 1.0
// ============================================================================
`default_nettype none

package snd_rom_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2
  } arb_state_e;

  localparam logic GNT_CPU = 1'b0;
  localparam logic GNT_AUX = 1'b1;

  localparam int DEF_ADDR_W = 12;
  localparam int DEF_DATA_W = 8;

endpackage

`default_nettype wire

// File: rtl/snd_rom_starve_ctr.sv
// ============================================================================
// snd_rom_starve_ctr : counts cpu wins while aux waits; forces an aux grant
// Rev 1.0
// ============================================================================
`default_nettype none

module snd_rom_starve_ctr #(
  parameter int STARVE_LIMIT = 8
) (
  input  logic clock_i,
  input  logic reset_i,
  input  logic idle_i,
  input  logic cpu_gnt_i,
  input  logic aux_gnt_i,
  input  logic aux_req_i,
  input  logic aux_elig_i,
  output logic force_aux_o
);

  localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

  logic [7:0] cnt_q;
  logic [7:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (idle_i) begin
      if (aux_gnt_i) begin
        cnt_d = 8'd0;
      end else if (cpu_gnt_i && aux_elig_i) begin
        // saturate so an unreachable limit can never wrap back to zero
        cnt_d = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
      end else if (!aux_req_i) begin
        cnt_d = 8'd0;
      end
    end
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      cnt_q <= 8'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign force_aux_o = (cnt_q == LIMIT) && aux_elig_i;

endmodule

`default_nettype wire

// File: rtl/snd_rom_arbiter.sv
// ============================================================================
// snd_rom_arbiter : cpu/aux sharing of a 1-cycle-latency sound ROM
// Optional starvation guard: define SND_ROM_ARB_STARVE_GUARD_EN.   Rev 1.0
// ============================================================================
`default_nettype none

module snd_rom_arbiter
  import snd_rom_arb_pkg::*;
#(
  parameter int ADDR_W       = DEF_ADDR_W,
  parameter int DATA_W       = DEF_DATA_W,
  parameter int STARVE_LIMIT = 8
) (
  input  logic              clock_i,
  input  logic              reset_i,
  input  logic              cpu_req_i,
  input  logic [ADDR_W-1:0] cpu_addr_i,
  output logic              cpu_ack_o,
  output logic [DATA_W-1:0] cpu_data_o,
  input  logic              aux_req_i,
  input  logic [ADDR_W-1:0] aux_addr_i,
  output logic              aux_ack_o,
  output logic [DATA_W-1:0] aux_data_o,
  output logic [ADDR_W-1:0] rom_addr_o,
  input  logic [DATA_W-1:0] rom_data_i,
  output logic              busy_o
);

  if (STARVE_LIMIT < 1 || STARVE_LIMIT > 255) begin : g_bad_starve_limit
    $error("snd_rom_arbiter: STARVE_LIMIT must be within 1..255");
  end

  arb_state_e        state_q, state_d;
  logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
  logic [DATA_W-1:0] cpu_data_q, cpu_data_d;
  logic [DATA_W-1:0] aux_data_q, aux_data_d;
  logic              cpu_ack_q, cpu_ack_d;
  logic              aux_ack_q, aux_ack_d;
  logic              gnt_q, gnt_d;

  logic idle;
  logic cpu_elig;
  logic aux_elig;
  logic force_aux;
  logic cpu_gnt;
  logic aux_gnt;

  // a requester's own ack cycle masks its req, giving it one cycle to drop it
  assign idle     = (state_q == ST_IDLE);
  assign cpu_elig = cpu_req_i && !cpu_ack_q;
  assign aux_elig = aux_req_i && !aux_ack_q;
  assign cpu_gnt  = idle && cpu_elig && !force_aux;
  assign aux_gnt  = idle && aux_elig && !cpu_gnt;

`ifdef SND_ROM_ARB_STARVE_GUARD_EN
  snd_rom_starve_ctr #(
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_starve_ctr (
    .clock_i     (clock_i),
    .reset_i     (reset_i),
    .idle_i      (idle),
    .cpu_gnt_i   (cpu_gnt),
    .aux_gnt_i   (aux_gnt),
    .aux_req_i   (aux_req_i),
    .aux_elig_i  (aux_elig),
    .force_aux_o (force_aux)
  );
`else
  assign force_aux = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    rom_addr_d = rom_addr_q;
    cpu_data_d = cpu_data_q;
    aux_data_d = aux_data_q;
    cpu_ack_d  = 1'b0;
    aux_ack_d  = 1'b0;
    gnt_d      = gnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (cpu_gnt) begin
          rom_addr_d = cpu_addr_i;
          gnt_d      = GNT_CPU;
          state_d    = ST_ADDR;
        end else if (aux_gnt) begin
          rom_addr_d = aux_addr_i;
          gnt_d      = GNT_AUX;
          state_d    = ST_ADDR;
        end
      end
      ST_ADDR: begin
        state_d = ST_DATA;
      end
      ST_DATA: begin
        if (gnt_q == GNT_CPU) begin
          cpu_data_d = rom_data_i;
          cpu_ack_d  = 1'b1;
        end else begin
          aux_data_d = rom_data_i;
          aux_ack_d  = 1'b1;
        end
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q    <= ST_IDLE;
      rom_addr_q <= '0;
      cpu_data_q <= '0;
      aux_data_q <= '0;
      cpu_ack_q  <= 1'b0;
      aux_ack_q  <= 1'b0;
      gnt_q      <= GNT_CPU;
    end else begin
      state_q    <= state_d;
      rom_addr_q <= rom_addr_d;
      cpu_data_q <= cpu_data_d;
      aux_data_q <= aux_data_d;
      cpu_ack_q  <= cpu_ack_d;
      aux_ack_q  <= aux_ack_d;
      gnt_q      <= gnt_d;
    end
  end

  assign rom_addr_o = rom_addr_q;
  assign cpu_data_o = cpu_data_q;
  assign aux_data_o = aux_data_q;
  assign cpu_ack_o  = cpu_ack_q;
  assign aux_ack_o  = aux_ack_q;
  assign busy_o     = !idle;

endmodule

`default_nettype wire
